// File: rtl/instr_prefetch_reg.sv
`default_nettype none
// instr_prefetch_reg: DEPTH-entry instruction prefetch queue; the head entry is the current instruction.
// Rev 1.0 - initial release.
module instr_prefetch_reg #(
   parameter int DATA_W  = 8,
   parameter int OPC_W   = 4,
   parameter int DEPTH   = 4,
   parameter int NOP_OPC = 0
) (
   input  logic                          clk,
   input  logic                          clr,
   input  logic [DATA_W-1:0]             busin,
   input  logic                          wa,
   input  logic                          adv,
   input  logic                          flush,
   input  logic                          oa,
   output logic [OPC_W-1:0]              instout,
   output logic [DATA_W-OPC_W-1:0]       operout,
   output logic                          full,
   output logic                          empty,
   output logic [$clog2(DEPTH):0]        count,
   output logic                          ovf
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int OPR_W = DATA_W - OPC_W;
   localparam logic [OPC_W-1:0] NOP = OPC_W'(NOP_OPC);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  rp;
   logic [PTR_W-1:0]  wp;
   logic              push;
   logic              pop;

   assign full  = (count == CNT_W'(DEPTH));
   assign empty = (count == '0);

   // A full queue still accepts a write when the head retires on the same edge.
   assign push = wa & (~full | adv);
   assign pop  = adv & ~empty;

   always_ff @(posedge clk) begin
      if (clr) begin
         rp    <= '0;
         wp    <= '0;
         count <= '0;
         ovf   <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (flush) begin
         rp    <= '0;
         wp    <= '0;
         count <= '0;
         ovf   <= 1'b0;
      end else begin
         if (push) begin
            mem[wp] <= busin;
            wp      <= wp + PTR_W'(1);
         end
         if (pop) begin
            rp <= rp + PTR_W'(1);
         end
         if (push && !pop) begin
            count <= count + CNT_W'(1);
         end else if (pop && !push) begin
            count <= count - CNT_W'(1);
         end
         if (wa && full && !adv) begin
            ovf <= 1'b1;
         end
      end
   end

   assign instout = empty ? NOP : mem[rp][DATA_W-1 -: OPC_W];
   // Never drive stale data: operand bus released whenever the queue is empty.
   assign operout = (oa && !empty) ? mem[rp][OPR_W-1:0] : {OPR_W{1'bz}};

endmodule
`default_nettype wire

// File: tb/tb_instr_prefetch_reg.sv
`default_nettype none
// tb_instr_prefetch_reg: directed plan plus random traffic against a queue-based reference model.
module tb_instr_prefetch_reg;

   localparam int DATA_W  = 8;
   localparam int OPC_W   = 4;
   localparam int DEPTH   = 4;
   localparam int NOP_OPC = 0;
   localparam int OPR_W   = DATA_W - OPC_W;
   localparam int PTR_W   = $clog2(DEPTH);
   localparam int CNT_W   = PTR_W + 1;

   logic              clk = 1'b0;
   logic              clr = 1'b0;
   logic              wa = 1'b0;
   logic              adv = 1'b0;
   logic              flush = 1'b0;
   logic              oa = 1'b0;
   logic [DATA_W-1:0] busin = '0;
   wire  [OPC_W-1:0]  instout;
   wire  [OPR_W-1:0]  operout;
   wire               full;
   wire               empty;
   wire  [CNT_W-1:0]  count;
   wire               ovf;

   instr_prefetch_reg #(
      .DATA_W (DATA_W),
      .OPC_W  (OPC_W),
      .DEPTH  (DEPTH),
      .NOP_OPC(NOP_OPC)
   ) dut (
      .clk    (clk),
      .clr    (clr),
      .busin  (busin),
      .wa     (wa),
      .adv    (adv),
      .flush  (flush),
      .oa     (oa),
      .instout(instout),
      .operout(operout),
      .full   (full),
      .empty  (empty),
      .count  (count),
      .ovf    (ovf)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   logic [DATA_W-1:0] mq[$];
   bit                m_ovf = 1'b0;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic check_all(input string tag);
      logic [OPR_W-1:0] zv;
      logic [OPR_W-1:0] exp_opr;
      logic [OPC_W-1:0] exp_opc;
      logic [PTR_W-1:0] pdiff;
      zv = {OPR_W{1'bz}};
      if (mq.size() == 0) begin
         exp_opc = OPC_W'(NOP_OPC);
         exp_opr = zv;
      end else begin
         exp_opc = mq[0][DATA_W-1 -: OPC_W];
         exp_opr = mq[0][OPR_W-1:0];
      end
      check({tag, ".count"}, 16'(count), 16'(mq.size()));
      check({tag, ".full"},  16'(full),  16'(mq.size() == DEPTH));
      check({tag, ".empty"}, 16'(empty), 16'(mq.size() == 0));
      check({tag, ".ovf"},   16'(ovf),   16'(m_ovf));
      check({tag, ".instout"}, 16'(instout), 16'(exp_opc));
      oa = 1'b1;
      #1;
      check({tag, ".operout_oa1"}, 16'(operout), 16'(exp_opr));
      oa = 1'b0;
      #1;
      check({tag, ".operout_oa0"}, 16'(operout), 16'(zv));
      pdiff = dut.wp - dut.rp;
      check({tag, ".ptr_inv"}, 16'(pdiff), 16'(mq.size() % DEPTH));
      check({tag, ".cnt_le"}, 16'(count <= CNT_W'(DEPTH)), 16'(1));
   endtask

   task automatic cycle(input string tag, input bit c, input bit w, input bit a,
                        input bit f, input logic [DATA_W-1:0] b);
      bit do_push;
      bit do_pop;
      clr = c; wa = w; adv = a; flush = f; busin = b;
      @(posedge clk);
      if (c || f) begin
         mq.delete();
         m_ovf = 1'b0;
      end else begin
         do_push = w && (mq.size() < DEPTH || a);
         do_pop  = a && (mq.size() > 0);
         if (w && mq.size() == DEPTH && !a) m_ovf = 1'b1;
         if (do_pop)  void'(mq.pop_front());
         if (do_push) mq.push_back(b);
      end
      #1;
      clr = 1'b0; wa = 1'b0; adv = 1'b0; flush = 1'b0;
      check_all(tag);
   endtask

   initial begin
      logic [DATA_W-1:0] fill1 [4];
      logic [DATA_W-1:0] fill2 [4];
      fill1 = '{8'h1A, 8'h2B, 8'h3C, 8'h4D};
      fill2 = '{8'h11, 8'h22, 8'h33, 8'h44};

      cycle("reset", 1, 0, 0, 0, 8'h00);
      foreach (fill1[i]) cycle("fill", 0, 1, 0, 0, fill1[i]);
      cycle("ovf_push", 0, 1, 0, 0, 8'h5E);
      for (int i = 0; i < 4; i++) cycle("drain1", 0, 0, 1, 0, 8'h00);

      foreach (fill2[i]) cycle("refill", 0, 1, 0, 0, fill2[i]);
      cycle("full_pushpop", 0, 1, 1, 0, 8'h55);
      for (int i = 0; i < 4; i++) cycle("drain2", 0, 0, 1, 0, 8'h00);

      cycle("empty_wa_adv", 0, 1, 1, 0, 8'h7F);
      cycle("pop_last", 0, 0, 1, 0, 8'h00);
      cycle("adv_empty", 0, 0, 1, 0, 8'h00);

      for (int i = 0; i < 4; i++) cycle("fill3", 0, 1, 0, 0, 8'(8'h61 + i));
      cycle("ovf2", 0, 1, 0, 0, 8'hEE);
      cycle("to3", 0, 0, 1, 0, 8'h00);
      cycle("flush_wa", 0, 1, 0, 1, 8'h99);
      cycle("after_flush", 0, 1, 0, 0, 8'h99);

      cycle("two", 0, 1, 0, 0, 8'hC3);
      cycle("clr_mid", 1, 1, 1, 0, 8'hD5);

      for (int i = 0; i < 400; i++) begin
         cycle("rand",
               ($urandom_range(0, 49) == 0),
               ($urandom_range(0, 9) < 6),
               ($urandom_range(0, 9) < 4),
               ($urandom_range(0, 19) == 0),
               8'($urandom));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete, got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
